gpio_sampler: RTL and testbench
===============================

GPIO_SAMPLER -- requirements
Module: gpio_sampler

Interface
REQ-001 Parameter size_addr, default 1: width of the address output; SHALL be >= 1.
REQ-002 Parameter size, default 2: number of 8-bit input bytes; SHALL satisfy size <= 2**size_addr.
REQ-003 Parameter debounce, default 4: consecutive mismatching cycles needed to accept a bit change; SHALL be >= 1.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 pins  input  8*size  asynchronous external pin levels; byte k is pins[8k+7:8k].
REQ-007 write  output  1  write strobe to the downstream GPIO register block.
REQ-008 address  output  size_addr  byte index being written.
REQ-009 data_out  output  8  debounced byte value being written.
REQ-010 ready_w  input  1  write acknowledge from the downstream block, returned one cycle after write.

Function
REQ-011 Each pin bit SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Per bit: a counter SHALL clear whenever the synchronized value equals the stable value and increment while it differs.
REQ-013 When the counter equals debounce-1 and the value still differs, the stable bit SHALL take the synchronized value and the counter SHALL clear.
REQ-014 A glitch shorter than debounce cycles SHALL never change the stable value.
REQ-015 Per byte: a dirty flag SHALL set on the edge its stable byte changes.
REQ-016 FSM states SHALL be IDLE, WRITE and WAIT.
REQ-017 IDLE -> WRITE when any dirty flag is set, selecting round-robin starting from the index after the last written byte.
REQ-018 On the IDLE -> WRITE transition, address and data_out SHALL be registered and the selected dirty flag cleared.
REQ-019 In WRITE, write SHALL be high for exactly one cycle; then WRITE -> WAIT.
REQ-020 In WAIT, address and data_out SHALL hold; WAIT -> IDLE on ready_w=1.
REQ-021 write SHALL be low in every state other than WRITE.
REQ-022 Dirty set and clear on the same edge: set SHALL win, so a change during capture is re-sent.
REQ-023 Latency from a stable pin change to write=1 SHALL be debounce+3 clock edges with the FSM idle.
REQ-024 The round-robin pointer SHALL wrap from size-1 to 0.
REQ-025 Bytes with index >= size SHALL never be addressed.

Reset
REQ-026 When reset=1, the following SHALL be cleared on the next edge: synchronizers, stable values, counters, dirty flags, pointer, FSM (-> IDLE), write, address, data_out.
REQ-027 Because stable resets to 0x00, matching the downstream reset contents, no write SHALL follow reset while pins are low.
REQ-028 Reset during WRITE or WAIT SHALL abort the transfer without re-sending it.

Configuration
REQ-029 With macro GPIO_SAMPLER_IRQ_EN defined, ports SHALL add irq (output 1) and irq_ack (input 1).
REQ-030 With GPIO_SAMPLER_IRQ_EN, irq SHALL set on each accepted write (WAIT with ready_w=1) and clear on irq_ack=1; on the same edge, set SHALL win.
REQ-031 Without GPIO_SAMPLER_IRQ_EN, neither port nor any irq logic SHALL exist.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings and the debounce counter width function (clog2 of debounce).
REQ-033 Per-bit synchronizer plus debounce SHALL be sub-module gpio_debounce, instantiated 8*size times.

Verification
REQ-034 Reset, pins=0x0000 for 50 cycles -> write never asserted, data_out=0x00, address=0.
REQ-035 pins byte0 0x00->0x5A held -> write=1 at edge 7 after the change, address=0, data_out=0x5A, then WAIT until ready_w.
REQ-036 Bit0 pulse of 3 cycles with debounce=4 -> no write; a 4-cycle pulse -> two writes (0x01, then 0x00).
REQ-037 Both bytes change on the same edge (0x00->0x11, 0x00->0x22) -> writes to address 0 then address 1; each write SHALL wait for the prior ready_w.
REQ-038 ready_w withheld 10 cycles -> address and data_out stable, write low throughout; a byte1 change during the wait is written after.
REQ-039 With GPIO_SAMPLER_IRQ_EN: an accepted write -> irq=1; irq_ack and a new accept on the same cycle -> irq stays 1.

Source files
------------

// File: rtl/gpio_sampler_pkg.sv
// rtl/gpio_sampler_pkg.sv - shared FSM encodings and debounce counter sizing for gpio_sampler
package gpio_sampler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // clog2 of debounce, kept at least one bit so debounce=1 still has a legal counter
   function automatic int cnt_width(input int debounce);
      return (debounce <= 1) ? 1 : $clog2(debounce);
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin two-flop synchronizer and debounce filter
module gpio_debounce
   import gpio_sampler_pkg::*;
#(
   parameter int debounce = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_stable,
   output logic o_accept
);

   localparam int CW = cnt_width(debounce);
   localparam logic [CW-1:0] CNT_LAST = CW'(debounce - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          w_diff;

   assign w_diff   = (r_sync2 != r_stable);
   // Pulses on the edge where stable flips; the top uses it to mark the byte dirty
   assign o_accept = w_diff && (r_cnt == CNT_LAST);
   assign o_stable = r_stable;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (o_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/gpio_sampler.sv
// rtl/gpio_sampler.sv - debounced GPIO byte sampler pushing changed bytes to a register block
// Optional interrupt output enabled by macro GPIO_SAMPLER_IRQ_EN.
module gpio_sampler
   import gpio_sampler_pkg::*;
#(
   parameter int size_addr = 1,
   parameter int size      = 2,
   parameter int debounce  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [8*size-1:0]    i_pins,
   output logic                 o_write,
   output logic [size_addr-1:0] o_address,
   output logic [7:0]           o_data_out,
   input  logic                 i_ready_w
`ifdef GPIO_SAMPLER_IRQ_EN
   ,
   output logic                 o_irq,
   input  logic                 i_irq_ack
`endif
);

   state_t               r_state;
   state_t               w_next;
   logic [8*size-1:0]    w_stable;
   logic [8*size-1:0]    w_accept;
   logic [7:0]           w_bytes [size];
   logic [size-1:0]      w_set;
   logic [size-1:0]      w_pick;
   logic [size-1:0]      r_dirty;
   logic                 w_found;
   logic                 w_take;
   logic [size_addr-1:0] w_sel;
   logic [size_addr-1:0] r_ptr;
   logic [size_addr-1:0] r_addr;
   logic [7:0]           w_byte;
   logic [7:0]           r_data;

   for (genvar b = 0; b < 8*size; b++) begin : g_bit
      gpio_debounce #(.debounce(debounce)) u_debounce (
         .clk      (clk),
         .reset    (reset),
         .i_pin    (i_pins[b]),
         .o_stable (w_stable[b]),
         .o_accept (w_accept[b])
      );
   end

   for (genvar k = 0; k < size; k++) begin : g_byte
      assign w_bytes[k] = w_stable[8*k +: 8];
      assign w_set[k]   = |w_accept[8*k +: 8];
   end

   // Round-robin pick: first dirty byte at or after r_ptr, wrapping past size-1
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sel   = '0;
      w_byte  = '0;
      for (int i = 0; i < size; i++) begin
         for (int k = 0; k < size; k++) begin
            if (!w_found && r_dirty[k] &&
                ((int'(r_ptr) + i == k) || (int'(r_ptr) + i == k + size))) begin
               w_found   = 1'b1;
               w_pick[k] = 1'b1;
               w_sel     = size_addr'(k);
               w_byte    = w_bytes[k];
            end
         end
      end
   end

   assign w_take = (r_state == ST_IDLE) && w_found;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_found) w_next = ST_WRITE;
         ST_WRITE: w_next = ST_WAIT;
         ST_WAIT:  if (i_ready_w) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_write = (r_state == ST_WRITE);
   end

   assign o_address  = r_addr;
   assign o_data_out = r_data;

   // A set on the same edge as the capture clear wins, so a byte changing mid-capture is re-sent
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dirty <= '0;
         r_ptr   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_dirty <= (r_dirty & ~({size{w_take}} & w_pick)) | w_set;
         if (w_take) begin
            r_addr <= w_sel;
            r_data <= w_byte;
            r_ptr  <= (int'(w_sel) == size - 1) ? '0 : w_sel + size_addr'(1);
         end
      end
   end

`ifdef GPIO_SAMPLER_IRQ_EN
   logic r_irq;
   logic w_accepted;

   assign w_accepted = (r_state == ST_WAIT) && i_ready_w;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else if (w_accepted) begin
         r_irq <= 1'b1;
      end else if (i_irq_ack) begin
         r_irq <= 1'b0;
      end
   end

   assign o_irq = r_irq;
`endif

endmodule

// File: tb/tb_gpio_sampler.sv
// tb/tb_gpio_sampler.sv - directed self-checking bench for gpio_sampler (default parameters)
module tb_gpio_sampler;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] i_pins;
   logic        o_write;
   logic [0:0]  o_address;
   logic [7:0]  o_data_out;
   logic        i_ready_w;
   logic        o_irq;
   logic        i_irq_ack;

   int n_cmp = 0;
   int n_err = 0;

   gpio_sampler #(.size_addr(1), .size(2), .debounce(4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .i_pins     (i_pins),
      .o_write    (o_write),
      .o_address  (o_address),
      .o_data_out (o_data_out),
      .i_ready_w  (i_ready_w)
`ifdef GPIO_SAMPLER_IRQ_EN
      ,
      .o_irq      (o_irq),
      .i_irq_ack  (i_irq_ack)
`endif
   );

`ifndef GPIO_SAMPLER_IRQ_EN
   assign o_irq = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_pins = 16'h0000;
      i_ready_w = 1'b0;
      i_irq_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_write(input string tag, input int exp_addr, input int exp_data);
      int n;
      n = 0;
      @(negedge clk);
      while (!o_write && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_write"}, 32'(o_write), 32'd1);
      check_val({tag, "_addr"}, 32'(o_address), 32'(exp_addr));
      check_val({tag, "_data"}, 32'(o_data_out), 32'(exp_data));
   endtask

   // Called at the negedge where write is seen high; holds ready_w low for hold cycles
   task automatic ack_write(input string tag, input int exp_addr, input int exp_data,
                            input int hold, input logic [15:0] pins_during, input logic irq_ack);
      logic hi;
      logic moved;
      hi = 1'b0;
      moved = 1'b0;
      i_pins = pins_during;
      for (int i = 0; i < hold + 1; i++) begin
         @(negedge clk);
         hi |= o_write;
         if (32'(o_address) != 32'(exp_addr) || 32'(o_data_out) != 32'(exp_data)) moved = 1'b1;
      end
      check_val({tag, "_wait_write_low"}, 32'(hi), 32'd0);
      check_val({tag, "_wait_hold"}, 32'(moved), 32'd0);
      i_ready_w = 1'b1;
      i_irq_ack = irq_ack;
      @(negedge clk);
      i_ready_w = 1'b0;
      i_irq_ack = 1'b0;
`ifdef GPIO_SAMPLER_IRQ_EN
      check_val({tag, "_irq"}, 32'(o_irq), 32'd1);
`endif
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int cnt;
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (o_write) cnt++;
      end
      check_val(tag, 32'(cnt), 32'd0);
   endtask

   initial begin
      logic early;

      // Reset state and quiet bus with pins low
      do_reset();
      @(negedge clk);
      check_val("rst_write", 32'(o_write), 32'd0);
      check_val("rst_addr", 32'(o_address), 32'd0);
      check_val("rst_data", 32'(o_data_out), 32'd0);
      check_val("rst_irq", 32'(o_irq), 32'd0);
      expect_quiet("idle_50_nowrite", 50);
      check_val("idle_data", 32'(o_data_out), 32'd0);
      check_val("idle_addr", 32'(o_address), 32'd0);

      // Exact latency: write high on the 7th edge after the change
      i_pins = 16'h005A;
      early = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         early |= o_write;
      end
      check_val("lat_early", 32'(early), 32'd0);
      @(negedge clk);
      check_val("lat_write", 32'(o_write), 32'd1);
      check_val("lat_addr", 32'(o_address), 32'd0);
      check_val("lat_data", 32'(o_data_out), 32'h5A);
      ack_write("lat", 0, 8'h5A, 3, 16'h005A, 1'b0);
`ifdef GPIO_SAMPLER_IRQ_EN
      i_irq_ack = 1'b1;
      @(negedge clk);
      i_irq_ack = 1'b0;
      check_val("irq_cleared", 32'(o_irq), 32'd0);
`endif
      expect_quiet("lat_after_quiet", 10);

      // Glitch filtering
      do_reset();
      i_pins = 16'h0001;
      repeat (3) @(negedge clk);
      i_pins = 16'h0000;
      expect_quiet("glitch3_nowrite", 20);
      i_pins = 16'h0001;
      repeat (4) @(negedge clk);
      i_pins = 16'h0000;
      wait_write("pulse4_rise", 0, 8'h01);
      ack_write("pulse4_rise", 0, 8'h01, 0, 16'h0000, 1'b0);
      wait_write("pulse4_fall", 0, 8'h00);
      ack_write("pulse4_fall", 0, 8'h00, 0, 16'h0000, 1'b0);
      expect_quiet("pulse4_quiet", 15);

      // Both bytes on one edge: address 0 then 1, second waits for first ready_w
      do_reset();
      i_pins = 16'h2211;
      wait_write("both_b0", 0, 8'h11);
      ack_write("both_b0", 0, 8'h11, 5, 16'h2211, 1'b0);
      wait_write("both_b1", 1, 8'h22);
      ack_write("both_b1", 1, 8'h22, 0, 16'h2211, 1'b1);

      // Long ready_w wait with a byte1 change arriving during it
      i_pins = 16'h2233;
      wait_write("hold_b0", 0, 8'h33);
      ack_write("hold_b0", 0, 8'h33, 10, 16'h4433, 1'b0);
      wait_write("hold_b1", 1, 8'h44);
      ack_write("hold_b1", 1, 8'h44, 0, 16'h4433, 1'b0);

      // Round robin: after writing byte0 the pointer sits at 1, then wraps to 0
      i_pins = 16'h4477;
      wait_write("rr_b0", 0, 8'h77);
      ack_write("rr_b0", 0, 8'h77, 0, 16'h4477, 1'b0);
      i_pins = 16'h9988;
      wait_write("rr_first", 1, 8'h99);
      ack_write("rr_first", 1, 8'h99, 0, 16'h9988, 1'b0);
      wait_write("rr_wrap", 0, 8'h88);
      ack_write("rr_wrap", 0, 8'h88, 0, 16'h9988, 1'b0);
      expect_quiet("rr_quiet", 15);

      // Reset in WAIT aborts the transfer with no re-send
      do_reset();
      i_pins = 16'h00AB;
      wait_write("abort", 0, 8'hAB);
      @(negedge clk);
      reset = 1'b1;
      i_pins = 16'h0000;
      @(negedge clk);
      reset = 1'b0;
      check_val("abort_write", 32'(o_write), 32'd0);
      check_val("abort_addr", 32'(o_address), 32'd0);
      check_val("abort_data", 32'(o_data_out), 32'd0);
      check_val("abort_irq", 32'(o_irq), 32'd0);
      expect_quiet("abort_quiet", 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
